mp_add_seq: RTL and testbench

- Multi-precision add/subtract sequencer built around one N-bit carry-lookahead adder instance.
- Adds or subtracts operands of WORDS*N bits by passing them one N-bit word per cycle through the shared adder, LSW first, with the carry held in a register between words.
- Sits between a requester with a valid/ready operand interface and a consumer with a valid/ready result interface.
- Trades latency for area: one N-bit adder serves any operand width.

---
 rtl/mp_add_seq.sv | 182 ++++++++++++++++++
 tb/tb_mp_add_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: streams WORDS N-bit words LSW first
// through one parallel-prefix carry-lookahead adder, holding the carry between words.

module mp_add_cla #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         co
);

  // Kogge-Stone prefix over (generate, propagate); returns carries c[0..N]
  function automatic logic [N:0] cla_carries(input logic [N-1:0] g0,
                                             input logic [N-1:0] p0,
                                             input logic         ci);
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N-1:0] gn;
    logic [N-1:0] pn;
    logic [N:0]   c;
    g = g0;
    p = p0;
    for (int d = 1; d < N; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < N; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    c[0] = ci;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[i] | (p[i] & ci);
    end
    return c;
  endfunction

  logic [N-1:0] gen_s;
  logic [N-1:0] prop_s;
  logic [N:0]   carry_s;

  assign gen_s   = x & y;
  assign prop_s  = x ^ y;
  assign carry_s = cla_carries(gen_s, prop_s, cin);
  assign s       = prop_s ^ carry_s[N-1:0];
  assign co      = carry_s[N];

endmodule

module mp_add_seq #(
  parameter int N     = 32,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] sum,
  output logic               cout,
  output logic               ovf,
  output logic               busy
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   sum_r;
  logic           carry_r;
  logic           cout_r;
  logic           ovf_r;
  logic [IW-1:0]  idx_r;
  int unsigned    base_s;
  logic [N-1:0]   aw_s;
  logic [N-1:0]   bw_s;
  logic [N-1:0]   sw_s;
  logic           co_s;
  logic           last_s;

  assign base_s = N * int'(idx_r);
  assign aw_s   = a_r[base_s +: N];
  assign bw_s   = b_r[base_s +: N];
  assign last_s = (idx_r == LAST_IDX);

  mp_add_cla #(.N(N)) u_cla (
    .x   (aw_s),
    .y   (bw_s),
    .cin (carry_r),
    .s   (sw_s),
    .co  (co_s)
  );

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Operand capture and word-serial datapath; B is pre-inverted for subtract
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      sum_r   <= {W{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      idx_r   <= {IW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub;
            idx_r   <= {IW{1'b0}};
            sum_r   <= {W{1'b0}};
          end
        end
        RUN: begin
          sum_r[base_s +: N] <= sw_s;
          carry_r            <= co_s;
          if (last_s) begin
            cout_r <= co_s;
            ovf_r  <= (a_r[W-1] == b_r[W-1]) && (sw_s[N-1] != a_r[W-1]);
          end else begin
            idx_r <= idx_r + IW'(1'b1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r == RUN) || (state_r == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq: a 4x8-bit instance and a 1x8-bit instance,
// checked against an integer-arithmetic reference model.

module tb_mp_add_seq;

  localparam int N      = 8;
  localparam int WORDS0 = 4;
  localparam int WORDS1 = 1;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid0 = 1'b0, in_ready0, sub0 = 1'b0, out_valid0, out_ready0 = 1'b0;
  logic        cout0, ovf0, busy0;
  logic [31:0] a0 = 32'd0, b0 = 32'd0, sum0;
  logic        in_valid1 = 1'b0, in_ready1, sub1 = 1'b0, out_valid1, out_ready1 = 1'b0;
  logic        cout1, ovf1, busy1;
  logic [7:0]  a1 = 8'd0, b1 = 8'd0, sum1;

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   rnd_rdy = 1'b0;
  bit   b2b = 1'b0;

  always #5 clk = ~clk;

  mp_add_seq #(.N(N), .WORDS(WORDS0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .sub(sub0), .out_valid(out_valid0), .out_ready(out_ready0),
    .sum(sum0), .cout(cout0), .ovf(ovf0), .busy(busy0)
  );

  mp_add_seq #(.N(N), .WORDS(WORDS1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
  );

  // Reference: signed/unsigned integer arithmetic on a w-bit operand
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic s, input int w);
    exp_t            m;
    longint unsigned msk, ux, uy;
    longint          sx, sy, r, rr, hi, lo;
    msk  = (64'd1 << w) - 64'd1;
    ux   = {32'd0, x} & msk;
    uy   = {32'd0, y} & msk;
    sx   = ux[w-1] ? (longint'(ux) - longint'(64'd1 << w)) : longint'(ux);
    sy   = uy[w-1] ? (longint'(uy) - longint'(64'd1 << w)) : longint'(uy);
    r    = s ? (sx - sy) : (sx + sy);
    rr   = r & longint'(msk);
    hi   = longint'((64'd1 << (w - 1)) - 64'd1);
    lo   = -hi - 64'sd1;
    m.s  = rr[31:0];
    m.c  = s ? (ux >= uy) : ((((ux + uy) >> w) & 64'd1) != 64'd0);
    m.o  = (r > hi) || (r < lo);
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic flag_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op0(input logic [31:0] x, input logic [31:0] y, input logic s);
    int t = 0;
    while (!in_ready0 && t < 200) begin step(); t++; end
    if (!in_ready0) begin flag_fail("accept0"); return; end
    in_valid0 = 1'b1; a0 = x; b0 = y; sub0 = s;
    q0.push_back(model(x, y, s, N * WORDS0));
    step();
    in_valid0 = 1'b0;
  endtask

  task automatic do_op1(input logic [7:0] x, input logic [7:0] y, input logic s);
    int t = 0;
    while (!in_ready1 && t < 200) begin step(); t++; end
    if (!in_ready1) begin flag_fail("accept1"); return; end
    in_valid1 = 1'b1; a1 = x; b1 = y; sub1 = s;
    q1.push_back(model({24'd0, x}, {24'd0, y}, s, N * WORDS1));
    step();
    in_valid1 = 1'b0;
  endtask

  task automatic drain(input int which);
    int t = 0;
    while (((which == 0) ? q0.size() : q1.size()) != 0 && t < 400) begin step(); t++; end
    if (((which == 0) ? q0.size() : q1.size()) != 0) flag_fail("drain");
  endtask

  // Monitor for the 4-word instance: result compare and accept-to-valid latency
  initial begin
    int   cyc = 0, acc = 0;
    bit   pend = 1'b0, prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (out_valid0 && !prev && pend) begin
          chk("latency0", 64'(cyc - acc), 64'(WORDS0 + 1));
          pend = 1'b0;
        end
        if (out_valid0 && out_ready0) begin
          if (q0.size() == 0) flag_fail("unexpected0");
          else begin
            e = q0.pop_front();
            chk("sum0", {32'd0, sum0}, {32'd0, e.s});
            chk("cout0", {63'd0, cout0}, {63'd0, e.c});
            chk("ovf0", {63'd0, ovf0}, {63'd0, e.o});
          end
        end
        if (in_valid0 && in_ready0) begin acc = cyc; pend = 1'b1; end
      end
      prev = out_valid0;
    end
  end

  // Monitor for the single-word instance: results, latency, accept spacing
  initial begin
    int   cyc = 0, acc = 0, last_acc = 0;
    bit   pend = 1'b0, prev = 1'b0, have_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend = 1'b0;
        have_prev = 1'b0;
      end else begin
        if (out_valid1 && !prev && pend) begin
          chk("latency1", 64'(cyc - acc), 64'(WORDS1 + 1));
          pend = 1'b0;
        end
        if (out_valid1 && out_ready1) begin
          if (q1.size() == 0) flag_fail("unexpected1");
          else begin
            e = q1.pop_front();
            chk("sum1", {56'd0, sum1}, {56'd0, e.s[7:0]});
            chk("cout1", {63'd0, cout1}, {63'd0, e.c});
            chk("ovf1", {63'd0, ovf1}, {63'd0, e.o});
          end
        end
        if (in_valid1 && in_ready1) begin
          if (b2b && have_prev) chk("spacing1", 64'(cyc - last_acc), 64'd3);
          last_acc  = cyc;
          have_prev = b2b;
          acc  = cyc;
          pend = 1'b1;
        end
      end
      prev = out_valid1;
    end
  end

  // Random consumer backpressure
  initial begin
    forever begin
      step();
      if (rnd_rdy) out_ready0 = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    exp_t e;
    int   t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready0}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_sum", {32'd0, sum0}, 64'd0);
    chk("rst_cout_ovf", {62'd0, cout0, ovf0}, 64'd0);
    chk("rst_in_ready1", {63'd0, in_ready1}, 64'd1);
    step();

    out_ready0 = 1'b1;
    do_op0(32'h0000_00FF, 32'h0000_0001, 1'b0);
    do_op0(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    do_op0(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    do_op0(32'h0000_0000, 32'h0000_0001, 1'b1);
    do_op0(32'h8000_0000, 32'h0000_0001, 1'b1);
    do_op0(32'h0000_0005, 32'h0000_0005, 1'b1);
    drain(0);

    // Hold the result in DONE while the requester misbehaves
    out_ready0 = 1'b0;
    do_op0(32'hDEAD_BEEF, 32'h2152_4111, 1'b0);
    e = q0[0];
    t = 0;
    while (!out_valid0 && t < 20) begin step(); t++; end
    if (!out_valid0) flag_fail("bp_wait");
    repeat (5) begin
      in_valid0 = 1'b1;
      a0 = $urandom; b0 = $urandom; sub0 = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_sum", {32'd0, sum0}, {32'd0, e.s});
      chk("bp_cout_ovf", {62'd0, cout0, ovf0}, {62'd0, e.c, e.o});
      chk("bp_in_ready", {63'd0, in_ready0}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid0}, 64'd1);
      step();
    end
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
    step();
    @(negedge clk);
    chk("bp_release_in_ready", {63'd0, in_ready0}, 64'd1);
    chk("bp_release_out_valid", {63'd0, out_valid0}, 64'd0);
    step();
    do_op0(32'h0102_0304, 32'hF0F0_F0F0, 1'b1);
    drain(0);

    // Reset during the second RUN cycle discards the operation
    in_valid0 = 1'b1; a0 = 32'hAAAA_AAAA; b0 = 32'h5555_5555; sub0 = 1'b0;
    step();
    in_valid0 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", {63'd0, in_ready0}, 64'd1);
    chk("mid_rst_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy0}, 64'd0);
    chk("mid_rst_sum", {32'd0, sum0}, 64'd0);
    step();
    do_op0(32'h1234_5678, 32'h1111_1111, 1'b0);
    drain(0);

    rnd_rdy = 1'b1;
    repeat (40) begin
      do_op0($urandom, $urandom, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) step();
    end
    drain(0);
    rnd_rdy = 1'b0;
    out_ready0 = 1'b1;

    out_ready1 = 1'b1;
    do_op1(8'hF0, 8'h20, 1'b0);
    b2b = 1'b1;
    do_op1(8'h7F, 8'h01, 1'b0);
    do_op1(8'h00, 8'h01, 1'b1);
    do_op1(8'h80, 8'h01, 1'b1);
    b2b = 1'b0;
    drain(1);
    repeat (12) do_op1(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    drain(1);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
